// File: rtl/tlu_trig_ctrl.sv
// Trigger controller behind the TLU receivers: masked, vetoable majority
// coincidence, pulse/busy/dead-time sequencing and a one-deep record slot.
module tlu_trig_ctrl #(
    parameter int N_CH = 6
) (
    input  logic            CLK40,
    input  logic            RST,
    input  logic            EN,
    input  logic [N_CH-1:0] CH_VALID,
    input  logic [N_CH-1:0] CH_EN_MASK,
    input  logic [N_CH-1:0] CH_VETO_MASK,
    input  logic [3:0]      COINC_TH,
    input  logic [11:0]     TIME_STAMP,
    input  logic [3:0]      TRIG_LEN,
    input  logic [7:0]      DEAD_TIME,
    input  logic            DUT_BUSY,
    output logic            TRIG_OUT,
    output logic [31:0]     TRIG_CNT,
    output logic [15:0]     SKIP_CNT,
    output logic [31:0]     DATA,
    output logic            DATA_VALID,
    input  logic            DATA_READY,
    output logic            STATE_BUSY
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PULSE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DEAD  = 2'd3;

    function automatic logic [3:0] popcount4(input logic [N_CH-1:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < N_CH; i++) begin
            cnt = cnt + {3'd0, v[i]};
        end
        return cnt;
    endfunction

    logic [1:0]      state_r;
    logic [1:0]      state_nxt_s;
    logic [3:0]      len_cnt_r;
    logic [3:0]      len_cnt_nxt_s;
    logic [7:0]      dead_cnt_r;
    logic [7:0]      dead_cnt_nxt_s;
    logic            trig_nxt_s;
    logic            busy_meta_r;
    logic            busy_s_r;
    logic            trig_out_r;
    logic [31:0]     trig_cnt_r;
    logic [15:0]     skip_cnt_r;
    logic [31:0]     data_r;
    logic            data_valid_r;
    logic            state_busy_r;
    logic [N_CH-1:0] hit_s;
    logic [7:0]      hit_ext_s;
    logic [3:0]      hit_cnt_s;
    logic            veto_s;
    logic            coinc_s;
    logic            accept_s;
    logic [3:0]      trig_len_eff_s;

    // Coincidence and acceptance decision for the current cycle.
    always_comb begin
        hit_s          = CH_VALID & CH_EN_MASK;
        hit_cnt_s      = popcount4(hit_s);
        veto_s         = |(CH_VALID & CH_VETO_MASK);
        coinc_s        = (hit_cnt_s >= COINC_TH) && (COINC_TH != 4'd0) && !veto_s;
        accept_s       = coinc_s && EN && (state_r == ST_IDLE) && !busy_s_r && !data_valid_r;
        trig_len_eff_s = (TRIG_LEN == 4'd0) ? 4'd1 : TRIG_LEN;
    end

    // Zero-extend the hit pattern into the 8-bit record field.
    always_comb begin
        hit_ext_s             = 8'd0;
        hit_ext_s[N_CH-1:0]   = hit_s;
    end

    // Sequencer next-state: pulse length and dead time are down-counters.
    always_comb begin
        state_nxt_s    = state_r;
        len_cnt_nxt_s  = len_cnt_r;
        dead_cnt_nxt_s = dead_cnt_r;
        trig_nxt_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s   = ST_PULSE;
                    len_cnt_nxt_s = trig_len_eff_s;
                    trig_nxt_s    = 1'b1;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_PULSE: begin
                // len_cnt_r holds the pulse cycles remaining including this one
                if (len_cnt_r <= 4'd1) begin
                    state_nxt_s   = ST_WAIT;
                    len_cnt_nxt_s = 4'd0;
                end else begin
                    len_cnt_nxt_s = len_cnt_r - 4'd1;
                    trig_nxt_s    = 1'b1;
                end
            end
            ST_WAIT: begin
                if (!busy_s_r) begin
                    state_nxt_s    = ST_DEAD;
                    dead_cnt_nxt_s = DEAD_TIME;
                end else begin
                    state_nxt_s    = ST_WAIT;
                end
            end
            ST_DEAD: begin
                if (dead_cnt_r == 8'd0) begin
                    state_nxt_s    = ST_IDLE;
                end else begin
                    dead_cnt_nxt_s = dead_cnt_r - 8'd1;
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                len_cnt_nxt_s  = 4'd0;
                dead_cnt_nxt_s = 8'd0;
            end
        endcase
    end

    // DUT_BUSY two-stage synchronizer.
    always_ff @(posedge CLK40) begin
        if (RST) begin
            busy_meta_r <= 1'b0;
            busy_s_r    <= 1'b0;
        end else begin
            busy_meta_r <= DUT_BUSY;
            busy_s_r    <= busy_meta_r;
        end
    end

    // Sequencer state, counters and trigger pulse register.
    always_ff @(posedge CLK40) begin
        if (RST) begin
            state_r      <= ST_IDLE;
            len_cnt_r    <= 4'd0;
            dead_cnt_r   <= 8'd0;
            trig_out_r   <= 1'b0;
            state_busy_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            len_cnt_r    <= len_cnt_nxt_s;
            dead_cnt_r   <= dead_cnt_nxt_s;
            trig_out_r   <= trig_nxt_s;
            state_busy_r <= (state_nxt_s != ST_IDLE);
        end
    end

    // Trigger counter (wraps) and saturating skip counter.
    always_ff @(posedge CLK40) begin
        if (RST) begin
            trig_cnt_r <= 32'd0;
            skip_cnt_r <= 16'd0;
        end else begin
            if (accept_s) begin
                trig_cnt_r <= trig_cnt_r + 32'd1;
            end else begin
                trig_cnt_r <= trig_cnt_r;
            end
            if (coinc_s && !accept_s && (skip_cnt_r != 16'hFFFF)) begin
                skip_cnt_r <= skip_cnt_r + 16'd1;
            end else begin
                skip_cnt_r <= skip_cnt_r;
            end
        end
    end

    // Record slot: accept requires an empty slot, so load and drain never collide.
    always_ff @(posedge CLK40) begin
        if (RST) begin
            data_r       <= 32'd0;
            data_valid_r <= 1'b0;
        end else if (accept_s) begin
            data_r       <= {hit_ext_s, trig_cnt_r[11:0], TIME_STAMP};
            data_valid_r <= 1'b1;
        end else if (data_valid_r && DATA_READY) begin
            data_r       <= data_r;
            data_valid_r <= 1'b0;
        end else begin
            data_r       <= data_r;
            data_valid_r <= data_valid_r;
        end
    end

    assign TRIG_OUT   = trig_out_r;
    assign TRIG_CNT   = trig_cnt_r;
    assign SKIP_CNT   = skip_cnt_r;
    assign DATA       = data_r;
    assign DATA_VALID = data_valid_r;
    assign STATE_BUSY = state_busy_r;

endmodule

// File: tb/tb_tlu_trig_ctrl.sv
// Directed bench for tlu_trig_ctrl with a record scoreboard.
module tb_tlu_trig_ctrl;

    logic        CLK40 = 1'b0;
    logic        RST = 1'b1;
    logic        EN = 1'b0;
    logic [5:0]  CH_VALID = 6'd0;
    logic [5:0]  CH_EN_MASK = 6'h3F;
    logic [5:0]  CH_VETO_MASK = 6'd0;
    logic [3:0]  COINC_TH = 4'd2;
    logic [11:0] TIME_STAMP = 12'd0;
    logic [3:0]  TRIG_LEN = 4'd1;
    logic [7:0]  DEAD_TIME = 8'd0;
    logic        DUT_BUSY = 1'b0;
    logic        TRIG_OUT;
    logic [31:0] TRIG_CNT;
    logic [15:0] SKIP_CNT;
    logic [31:0] DATA;
    logic        DATA_VALID;
    logic        DATA_READY = 1'b1;
    logic        STATE_BUSY;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] sb_q[$];
    logic [31:0] trig_id = 32'd0;
    logic [31:0] held_rec;

    tlu_trig_ctrl #(.N_CH(6)) dut (
        .CLK40(CLK40), .RST(RST), .EN(EN), .CH_VALID(CH_VALID),
        .CH_EN_MASK(CH_EN_MASK), .CH_VETO_MASK(CH_VETO_MASK),
        .COINC_TH(COINC_TH), .TIME_STAMP(TIME_STAMP), .TRIG_LEN(TRIG_LEN),
        .DEAD_TIME(DEAD_TIME), .DUT_BUSY(DUT_BUSY), .TRIG_OUT(TRIG_OUT),
        .TRIG_CNT(TRIG_CNT), .SKIP_CNT(SKIP_CNT), .DATA(DATA),
        .DATA_VALID(DATA_VALID), .DATA_READY(DATA_READY), .STATE_BUSY(STATE_BUSY)
    );

    always #5 CLK40 = ~CLK40;

    task automatic tick();
        @(posedge CLK40);
        #1;
        TIME_STAMP = TIME_STAMP + 12'd1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected record for an accept in the current cycle.
    task automatic push_rec(input logic [7:0] hit);
        sb_q.push_back({hit, trig_id[11:0], TIME_STAMP});
        trig_id = trig_id + 32'd1;
    endtask

    // Scoreboard drain: a record is consumed at the next edge.
    always @(negedge CLK40) begin
        if (!RST && DATA_VALID && DATA_READY) begin
            n_cmp++;
            assert (sb_q.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_record observed=%h expected=none", DATA);
            end
            if (sb_q.size() != 0) begin
                logic [31:0] exp_rec;
                exp_rec = sb_q.pop_front();
                n_cmp++;
                assert (DATA === exp_rec) else begin
                    n_err++;
                    $error("FAIL record observed=%h expected=%h", DATA, exp_rec);
                end
            end
        end
    end

    initial begin
        // reset state
        tick(); tick();
        chk("rst_trig_out", {31'd0, TRIG_OUT}, 32'd0);
        chk("rst_trig_cnt", TRIG_CNT, 32'd0);
        chk("rst_skip_cnt", {16'd0, SKIP_CNT}, 32'd0);
        chk("rst_data_valid", {31'd0, DATA_VALID}, 32'd0);
        chk("rst_data", DATA, 32'd0);
        chk("rst_state_busy", {31'd0, STATE_BUSY}, 32'd0);
        RST = 1'b0;
        EN  = 1'b1;
        tick();

        // single two-channel coincidence
        TIME_STAMP = 12'h123;
        CH_VALID = 6'b000011;
        push_rec(8'h03);
        tick();
        CH_VALID = 6'd0;
        chk("t1_trig_hi", {31'd0, TRIG_OUT}, 32'd1);
        tick();
        chk("t1_trig_lo", {31'd0, TRIG_OUT}, 32'd0);
        chk("t1_trig_cnt", TRIG_CNT, 32'd1);
        chk("t1_skip_cnt", {16'd0, SKIP_CNT}, 32'd0);
        tick(); tick(); tick();

        // vetoed coincidence is not a coincidence
        CH_VETO_MASK = 6'b100000;
        CH_VALID = 6'b100011;
        tick();
        CH_VALID = 6'd0;
        chk("t2_trig", {31'd0, TRIG_OUT}, 32'd0);
        tick();
        chk("t2_data_valid", {31'd0, DATA_VALID}, 32'd0);
        chk("t2_skip_cnt", {16'd0, SKIP_CNT}, 32'd0);
        chk("t2_trig_cnt", TRIG_CNT, 32'd1);
        CH_VETO_MASK = 6'd0;

        // held coincidence through pulse, busy and dead time
        TRIG_LEN  = 4'd3;
        DEAD_TIME = 8'd5;
        for (int c = 0; c < 36; c++) begin
            DUT_BUSY = (c >= 2 && c <= 11);
            CH_VALID = (c <= 21) ? 6'b000011 : 6'd0;
            if (c == 0 || c == 21) push_rec(8'h03);
            tick();
            chk($sformatf("t3_trig_c%0d", c), {31'd0, TRIG_OUT},
                (c <= 2 || (c >= 21 && c <= 23)) ? 32'd1 : 32'd0);
        end
        DUT_BUSY = 1'b0;
        chk("t3_skip_cnt", {16'd0, SKIP_CNT}, 32'd20);
        chk("t3_trig_cnt", TRIG_CNT, 32'd3);
        chk("t3_state_busy", {31'd0, STATE_BUSY}, 32'd0);

        // stalled output slot: record held, later coincidences skipped
        TRIG_LEN   = 4'd1;
        DEAD_TIME  = 8'd0;
        DATA_READY = 1'b0;
        held_rec   = {8'h03, trig_id[11:0], TIME_STAMP};
        for (int k = 0; k < 80; k++) begin
            CH_VALID = (k % 8 == 0) ? 6'b000011 : 6'd0;
            if (k == 0) push_rec(8'h03);
            tick();
        end
        CH_VALID = 6'd0;
        chk("t4_data_held", DATA, held_rec);
        chk("t4_data_valid", {31'd0, DATA_VALID}, 32'd1);
        chk("t4_trig_cnt", TRIG_CNT, 32'd4);
        chk("t4_skip_cnt", {16'd0, SKIP_CNT}, 32'd29);
        DATA_READY = 1'b1;
        tick();
        chk("t4_drained", {31'd0, DATA_VALID}, 32'd0);
        CH_VALID = 6'b000011;
        push_rec(8'h03);
        tick();
        CH_VALID = 6'd0;
        chk("t4_next_trig", {31'd0, TRIG_OUT}, 32'd1);
        chk("t4_next_id", {20'd0, DATA[23:12]}, 32'd4);
        tick(); tick(); tick(); tick();

        // skip counter saturation
        DATA_READY = 1'b0;
        for (int i = 0; i <= 65600; i++) begin
            CH_VALID = 6'b000011;
            if (i == 0) push_rec(8'h03);
            tick();
        end
        CH_VALID = 6'd0;
        chk("t5_skip_sat", {16'd0, SKIP_CNT}, 32'h0000FFFF);
        chk("t5_trig_cnt", TRIG_CNT, 32'd6);

        // reset in the middle of a pulse
        TRIG_LEN   = 4'd4;
        DATA_READY = 1'b1;
        tick();
        DATA_READY = 1'b0;
        CH_VALID = 6'b000011;
        tick();
        CH_VALID = 6'd0;
        chk("t5_pulse_hi", {31'd0, TRIG_OUT}, 32'd1);
        chk("t5_busy_hi", {31'd0, STATE_BUSY}, 32'd1);
        RST = 1'b1;
        tick();
        chk("t5_rst_trig", {31'd0, TRIG_OUT}, 32'd0);
        chk("t5_rst_trig_cnt", TRIG_CNT, 32'd0);
        chk("t5_rst_skip_cnt", {16'd0, SKIP_CNT}, 32'd0);
        chk("t5_rst_valid", {31'd0, DATA_VALID}, 32'd0);
        chk("t5_rst_data", DATA, 32'd0);
        chk("t5_rst_state_busy", {31'd0, STATE_BUSY}, 32'd0);
        RST = 1'b0;
        trig_id = 32'd0;

        // resume with TRIG_LEN=0 behaving as 1
        TRIG_LEN   = 4'd0;
        DATA_READY = 1'b1;
        CH_VALID = 6'b000011;
        push_rec(8'h03);
        tick();
        CH_VALID = 6'd0;
        chk("t6_trig_hi", {31'd0, TRIG_OUT}, 32'd1);
        tick();
        chk("t6_trig_lo", {31'd0, TRIG_OUT}, 32'd0);
        chk("t6_trig_cnt", TRIG_CNT, 32'd1);
        tick(); tick(); tick();

        // threshold 0 disables coincidence entirely
        COINC_TH = 4'd0;
        CH_VALID = 6'h3F;
        tick(); tick();
        CH_VALID = 6'd0;
        chk("t7_th0_skip", {16'd0, SKIP_CNT}, 32'd0);
        chk("t7_th0_trig", {31'd0, TRIG_OUT}, 32'd0);
        chk("t7_th0_state", {31'd0, STATE_BUSY}, 32'd0);

        // coincidence while disabled is counted as skipped
        COINC_TH = 4'd2;
        EN = 1'b0;
        CH_VALID = 6'b000110;
        tick();
        CH_VALID = 6'd0;
        tick();
        chk("t8_en0_skip", {16'd0, SKIP_CNT}, 32'd1);
        chk("t8_en0_trig_cnt", TRIG_CNT, 32'd1);
        chk("t8_en0_trig", {31'd0, TRIG_OUT}, 32'd0);
        tick();

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tlu_trig_ctrl.md
Name: tlu_trig_ctrl

Overview:
- Trigger controller behind the per-channel TLU receivers in the 40 MHz domain.
- Takes the per-channel VALID strobes and forms a masked, vetoable majority coincidence.
- Sequences each accepted trigger through pulse, DUT-busy wait and dead time.
- Hands one timestamped trigger record per accepted trigger to the readout through a valid/ready slot, and counts coincidences it had to skip.

Parameters:
- N_CH, 6, number of receiver channels; legal range 1..8.

Ports:
- CLK40  input  1  single clock, 40 MHz.
- RST  input  1  synchronous, active-high reset.
- EN  input  1  trigger enable.
- CH_VALID  input  N_CH  per-channel VALID from the receivers (registered upstream).
- CH_EN_MASK  input  N_CH  channels that count toward coincidence.
- CH_VETO_MASK  input  N_CH  channels whose VALID vetoes a trigger.
- COINC_TH  input  4  minimum number of enabled channels hit; 0 disables triggering.
- TIME_STAMP  input  12  free-running coarse timestamp.
- TRIG_LEN  input  4  TRIG_OUT pulse length in cycles; 0 is treated as 1.
- DEAD_TIME  input  8  idle cycles after DUT_BUSY falls.
- DUT_BUSY  input  1  DUT busy; asynchronous source, double-registered inside the block.
- TRIG_OUT  output  1  trigger pulse to DUT.
- TRIG_CNT  output  32  number of accepted triggers.
- SKIP_CNT  output  16  number of coincidences not accepted; saturates.
- DATA  output  32  record: {8'(hit pattern, zero-extended), TRIG_CNT[11:0], TIME_STAMP[11:0]}.
- DATA_VALID  output  1  record available.
- DATA_READY  input  1  consumer accepts the record.
- STATE_BUSY  output  1  FSM not in IDLE.

Behaviour:
- hit = CH_VALID & CH_EN_MASK.
- veto = |(CH_VALID & CH_VETO_MASK).
- coinc = (popcount(hit) >= COINC_TH) & (COINC_TH != 0) & ~veto. Popcount is 4 bits wide.
- accept = coinc & EN & (state == IDLE) & ~busy_s & ~DATA_VALID. busy_s is the second synchronizer stage of DUT_BUSY.
- coinc & ~accept: SKIP_CNT increments, saturating at 16'hFFFF. This includes coincidences arriving while EN=0.
- FSM states IDLE, PULSE, WAIT_BUSY, DEAD.
  - IDLE: on accept, go to PULSE.
  - PULSE: TRIG_OUT=1 for max(TRIG_LEN,1) cycles, then go to WAIT_BUSY.
  - WAIT_BUSY: stay while busy_s=1; when busy_s=0, load the dead counter with DEAD_TIME and go to DEAD. If DUT_BUSY never rises, this state exits on its first cycle.
  - DEAD: count down; leave to IDLE on the cycle the counter equals 0. With DEAD_TIME=0, DEAD lasts 1 cycle.
- Accept timing (accept in cycle n; these take effect at edge n+1):
  - TRIG_OUT goes high.
  - DATA is loaded with the hit pattern, TIME_STAMP of cycle n, and the pre-increment TRIG_CNT. The first trigger carries ID 0.
  - DATA_VALID=1.
  - TRIG_CNT increments; it wraps from 32'hFFFFFFFF to 0.
- Shortest accept-to-accept spacing with TRIG_LEN=1, DEAD_TIME=0 and no busy: 4 cycles.
- Handshake: DATA and DATA_VALID are held stable until DATA_VALID & DATA_READY at an edge. DATA_VALID clears at that edge. A new accept can occur in the cycle after the clear. DATA_READY while DATA_VALID=0 is ignored.
- EN falling mid-sequence: the current sequence completes; no new accepts.
- EN does not affect the output slot.
- Mask and threshold changes take effect on the next cycle's evaluation.
- RST has priority over everything and takes effect at the next edge, including mid-pulse:
  - state=IDLE, TRIG_OUT=0, DATA_VALID=0, DATA=0.
  - TRIG_CNT=0, SKIP_CNT=0, dead counter=0.
  - both busy synchronizer stages=0.
- All outputs are registered.

Test Plan:
- N_CH=6, CH_EN_MASK=6'h3F, COINC_TH=2, DEAD_TIME=0, TRIG_LEN=1, DATA_READY=1, CH_VALID=6'b000011 for one cycle at TIME_STAMP=12'h123 -> TRIG_OUT high for exactly 1 cycle, one cycle later; DATA=32'h03000123; TRIG_CNT=1; SKIP_CNT=0.
- Same setup, CH_VETO_MASK=6'b100000, CH_VALID=6'b100011 -> no TRIG_OUT, no DATA_VALID; SKIP_CNT=0 because veto suppresses coinc.
- TRIG_LEN=3, DEAD_TIME=5, DUT_BUSY high for 10 cycles starting 1 cycle after TRIG_OUT rises, CH_VALID=6'b000011 held high -> TRIG_OUT high 3 cycles; next TRIG_OUT only after busy_s falls plus 6 DEAD cycles and 1 IDLE evaluation; SKIP_CNT equals the number of held coinc cycles not accepted.
- DATA_READY=0 after the first trigger, coincidences every 8 cycles for 80 cycles -> DATA holds the first record; TRIG_CNT=1; SKIP_CNT=9. Raise DATA_READY -> the record is consumed and the next coincidence is accepted with ID field 1.
- Force SKIP_CNT near saturation with >65535 blocked coincidences -> SKIP_CNT stays at 16'hFFFF. Assert RST during PULSE -> TRIG_OUT=0, both counters=0 and DATA_VALID=0 at the next edge, then normal triggering resumes.
